decode_stage_pipe: RTL and testbench
====================================

Name: decode_stage_pipe

Overview:
Parametrised, pipelined RV32I/RV64I decode stage that replaces the combinational decode unit, which relied on externally supplied type enables. Instruction type is derived internally from the opcode. Immediates are sign-extended to XLEN, and illegal encodings are flagged. Sits between fetch and register-read/execute, with valid/ready handshakes on both sides, a 2-entry elastic buffer and a flush input.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64. Sets the widths of immed_o, pc_i and pc_o.
SKID_EN, 1, 1 = 2-entry skid buffer (instr_ready_o is a register output); 0 = single register (instr_ready_o = !dec_valid_o || dec_ready_i).

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous, active-high reset
flush_i  in  1  discard all buffered entries
instr_valid_i  in  1  fetch presents an instruction
instr_ready_o  out  1  stage can accept
instr_i  in  32  instruction word
pc_i  in  XLEN  instruction PC
dec_valid_o  out  1  decoded entry valid
dec_ready_i  in  1  consumer accepts
pc_o  out  XLEN  PC of decoded entry
opcode_o  out  7  instr[6:0]
func3_o  out  3  instr[14:12]
func7_o  out  7  instr[31:25]
rs1_o, rs2_o, rd_o  out  5 each  register fields
immed_o  out  XLEN  sign-extended immediate
type_o  out  6  one-hot {UJ,U,SB,S,R,I}; 0 if illegal
illegal_o  out  1  illegal encoding
rd_we_o  out  1  writes rd (rd != 0)
rs1_used_o, rs2_used_o  out  1 each  operand usage

Behaviour:
- Reset (async, rst_i=1): all outputs 0 except instr_ready_o=1. Both buffer entries invalid. Any in-flight entry is lost.
- Accept when instr_valid_i && instr_ready_o. Decode is combinational on the input and registered, so an accepted instruction appears at the outputs 1 cycle after acceptance (latency 1).
- Output stability: while dec_valid_o && !dec_ready_i, all outputs hold.
- Skid (SKID_EN=1):
  - Entry accepted while the output entry is stalled goes to the skid register.
  - instr_ready_o = !skid_valid, registered.
  - When the output entry is consumed, the skid entry moves to the output the same edge.
  - Order is strictly preserved.
- Simultaneous accept and consume with an empty skid: new entry loads the output register directly; no bubble.
- flush_i=1: both valid bits clear on the next edge. An instruction accepted in the flush cycle is dropped. instr_ready_o=1 the following cycle. Flush has priority over accept and consume.
- Type decode by opcode:
  - I: 0000011, 0010011, 1100111, 1110011
  - R: 0110011
  - S: 0100011
  - SB: 1100011
  - U: 0110111, 0010111
  - UJ: 1101111
- Illegal when any of:
  - instr[1:0] != 11
  - unknown opcode
  - opcode 1100111 with func3 != 000
  - R-type with func7 not in {0000000, 0100000, 0000001}
  - SB with func3 in {010, 011}
  - When illegal: type_o=0, rd_we_o=0, rs*_used_o=0, immed_o=0; fields still passed through.
- Immediates (sign bit instr[31] replicated to XLEN):
  - I: instr[31:20]
  - S: {instr[31:25], instr[11:7]}
  - SB: {instr[31], instr[7], instr[30:25], instr[11:8], 0}
  - U: {instr[31:12], 12'b0}, sign-extended for XLEN=64
  - UJ: {instr[31], instr[19:12], instr[20], instr[30:21], 0}
  - R: 0
- Operand and write flags:
  - rd_we_o = (I|R|U|UJ) && rd != 0
  - rs1_used_o = I|R|S|SB, except U/UJ
  - rs2_used_o = R|S|SB

Test Plan:
- addi x1,x2,-1 (0xFFF10093), dec_ready_i=1 -> next cycle:
  - type_o=000001, rs1=2, rd=1
  - immed_o=0xFFFFFFFF, rd_we_o=1, rs2_used_o=0
- sw x5,8(x6) (0x00532423), then beq x0,x0,-4 (0xFE000EE3), then jal x1,2048 (0x001000EF), back-to-back ->
  - S: immed=8, rs1=6, rs2=5, rd_we=0
  - SB: immed=0xFFFFFFFC
  - UJ: immed=0x00000800, rd_we=1
  - One result per cycle; no bubbles.
- Backpressure: dec_ready_i=0, push A, B, C ->
  - A held at outputs; B in skid; instr_ready_o=0; C stalled.
  - Raise dec_ready_i -> A, B, C emerge in order over 3 cycles.
- Illegal: 0x00000000 and 0x0000A067 (jalr func3=010) -> illegal_o=1, type_o=0, rd_we_o=0.
- Flush while two entries are stalled, plus a concurrent valid input ->
  - dec_valid_o=0 next cycle; instr_ready_o=1.
  - Concurrent input never emerges.
- XLEN=64: lui x1,0x80000 (0x800000B7) -> immed_o=0xFFFFFFFF80000000.
- Reset: assert rst_i mid-stall -> outputs 0 immediately (asynchronous), instr_ready_o=1.

Source files
------------

// File: rtl/decode_stage_pipe_if.sv
// Fetch-side and consumer-side handshake bundle for the decode stage.
// The master modport is the environment (fetch + consumer); slave is the stage.
`timescale 1ns/1ps
interface decode_stage_pipe_if #(
   parameter int XLEN = 32
);
   logic            flush_i;
   logic            instr_valid_i;
   logic            instr_ready_o;
   logic [31:0]     instr_i;
   logic [XLEN-1:0] pc_i;
   logic            dec_valid_o;
   logic            dec_ready_i;
   logic [XLEN-1:0] pc_o;
   logic [6:0]      opcode_o;
   logic [2:0]      func3_o;
   logic [6:0]      func7_o;
   logic [4:0]      rs1_o;
   logic [4:0]      rs2_o;
   logic [4:0]      rd_o;
   logic [XLEN-1:0] immed_o;
   logic [5:0]      type_o;
   logic            illegal_o;
   logic            rd_we_o;
   logic            rs1_used_o;
   logic            rs2_used_o;

   modport slave (
      input  flush_i, instr_valid_i, instr_i, pc_i, dec_ready_i,
      output instr_ready_o, dec_valid_o, pc_o, opcode_o, func3_o, func7_o,
             rs1_o, rs2_o, rd_o, immed_o, type_o, illegal_o, rd_we_o,
             rs1_used_o, rs2_used_o
   );

   modport master (
      output flush_i, instr_valid_i, instr_i, pc_i, dec_ready_i,
      input  instr_ready_o, dec_valid_o, pc_o, opcode_o, func3_o, func7_o,
             rs1_o, rs2_o, rd_o, immed_o, type_o, illegal_o, rd_we_o,
             rs1_used_o, rs2_used_o
   );
endinterface

// File: rtl/decode_stage_pipe.sv
// Pipelined RV32I/RV64I decode stage. Instruction type comes from the opcode,
// immediates are sign-extended to XLEN and illegal encodings are flagged.
// An output register plus an optional skid register give a 2-entry elastic
// buffer; with the skid enabled instr_ready_o comes straight from a flop.
`timescale 1ns/1ps
module decode_stage_pipe #(
   parameter int XLEN    = 32,
   parameter bit SKID_EN = 1'b1
) (
   input logic                clk_i,
   input logic                rst_i,
   decode_stage_pipe_if.slave bus
);

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [6:0]      opcode;
      logic [2:0]      func3;
      logic [6:0]      func7;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic [XLEN-1:0] immed;
      logic [5:0]      typ;
      logic            illegal;
      logic            rd_we;
      logic            rs1_used;
      logic            rs2_used;
   } entry_t;

   entry_t      dec_new;
   logic [31:0] ins;
   logic        is_i, is_r, is_s, is_sb, is_u, is_uj;
   logic        ill;
   logic [31:0] imm32;

   entry_t out_d, out_q;
   entry_t skid_d, skid_q;
   logic   out_valid_d, out_valid_q;
   logic   skid_valid_d, skid_valid_q;
   logic   instr_ready_d, instr_ready_q;
   logic   instr_ready;
   logic   accept;

   assign ins = bus.instr_i;

   // Classify the incoming word, check legality and build its decoded entry.
   always_comb begin
      is_i  = 1'b0;
      is_r  = 1'b0;
      is_s  = 1'b0;
      is_sb = 1'b0;
      is_u  = 1'b0;
      is_uj = 1'b0;
      case (ins[6:0])
         7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011: is_i  = 1'b1;
         7'b0110011:                                     is_r  = 1'b1;
         7'b0100011:                                     is_s  = 1'b1;
         7'b1100011:                                     is_sb = 1'b1;
         7'b0110111, 7'b0010111:                         is_u  = 1'b1;
         7'b1101111:                                     is_uj = 1'b1;
         default: ;
      endcase

      ill = (ins[1:0] != 2'b11)
         || !(is_i || is_r || is_s || is_sb || is_u || is_uj)
         || ((ins[6:0] == 7'b1100111) && (ins[14:12] != 3'b000))
         || (is_r && !((ins[31:25] == 7'b0000000) || (ins[31:25] == 7'b0100000)
                       || (ins[31:25] == 7'b0000001)))
         || (is_sb && (ins[14:13] == 2'b01));

      // Every immediate fits in 32 bits signed; widening to XLEN is one sign-extension.
      imm32 = 32'd0;
      if (ill)        imm32 = 32'd0;
      else if (is_i)  imm32 = {{20{ins[31]}}, ins[31:20]};
      else if (is_s)  imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      else if (is_sb) imm32 = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      else if (is_u)  imm32 = {ins[31:12], 12'd0};
      else if (is_uj) imm32 = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};

      dec_new.pc       = bus.pc_i;
      dec_new.opcode   = ins[6:0];
      dec_new.func3    = ins[14:12];
      dec_new.func7    = ins[31:25];
      dec_new.rs1      = ins[19:15];
      dec_new.rs2      = ins[24:20];
      dec_new.rd       = ins[11:7];
      dec_new.immed    = XLEN'($signed(imm32));
      dec_new.typ      = ill ? 6'd0 : {is_uj, is_u, is_sb, is_s, is_r, is_i};
      dec_new.illegal  = ill;
      dec_new.rd_we    = !ill && (is_i || is_r || is_u || is_uj) && (ins[11:7] != 5'd0);
      dec_new.rs1_used = !ill && (is_i || is_r || is_s || is_sb);
      dec_new.rs2_used = !ill && (is_r || is_s || is_sb);
   end

   // Without the skid register the stage can only accept when the output slot frees.
   assign instr_ready = SKID_EN ? instr_ready_q : (!out_valid_q || bus.dec_ready_i);
   assign accept      = bus.instr_valid_i && instr_ready;

   // Elastic buffer control: flush beats everything, the skid entry drains first.
   always_comb begin
      out_d        = out_q;
      skid_d       = skid_q;
      out_valid_d  = out_valid_q;
      skid_valid_d = skid_valid_q;
      if (bus.flush_i) begin
         out_valid_d  = 1'b0;
         skid_valid_d = 1'b0;
      end else if (!out_valid_q || bus.dec_ready_i) begin
         if (skid_valid_q) begin
            out_d        = skid_q;
            out_valid_d  = 1'b1;
            skid_valid_d = 1'b0;
         end else if (accept) begin
            out_d       = dec_new;
            out_valid_d = 1'b1;
         end else begin
            out_valid_d = 1'b0;
         end
      end else if (accept && SKID_EN) begin
         skid_d       = dec_new;
         skid_valid_d = 1'b1;
      end
      instr_ready_d = !skid_valid_d;
   end

   // State registers; reset empties both entries and opens the input.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         out_q         <= '0;
         skid_q        <= '0;
         out_valid_q   <= 1'b0;
         skid_valid_q  <= 1'b0;
         instr_ready_q <= 1'b1;
      end else begin
         out_q         <= out_d;
         skid_q        <= skid_d;
         out_valid_q   <= out_valid_d;
         skid_valid_q  <= skid_valid_d;
         instr_ready_q <= instr_ready_d;
      end
   end

   assign bus.instr_ready_o = instr_ready;
   assign bus.dec_valid_o   = out_valid_q;
   assign bus.pc_o          = out_q.pc;
   assign bus.opcode_o      = out_q.opcode;
   assign bus.func3_o       = out_q.func3;
   assign bus.func7_o       = out_q.func7;
   assign bus.rs1_o         = out_q.rs1;
   assign bus.rs2_o         = out_q.rs2;
   assign bus.rd_o          = out_q.rd;
   assign bus.immed_o       = out_q.immed;
   assign bus.type_o        = out_q.typ;
   assign bus.illegal_o     = out_q.illegal;
   assign bus.rd_we_o       = out_q.rd_we;
   assign bus.rs1_used_o    = out_q.rs1_used;
   assign bus.rs2_used_o    = out_q.rs2_used;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Bench for decode_stage_pipe: an XLEN=32 and an XLEN=64 instance share one
// stimulus stream; accepted words are pushed into per-instance queues of
// expected entries and output monitors pop and compare.
`timescale 1ns/1ps
module tb_decode_stage_pipe;

   typedef struct packed {
      logic [63:0] pc;
      logic [6:0]  opcode;
      logic [2:0]  func3;
      logic [6:0]  func7;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [63:0] immed;
      logic [5:0]  typ;
      logic        illegal;
      logic        rd_we;
      logic        rs1_used;
      logic        rs2_used;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        flush, valid, dec_ready;
   logic [31:0] instr;
   logic [63:0] pc;

   int   checks   = 0;
   int   failures = 0;
   exp_t q32[$];
   exp_t q64[$];

   always #5 clk = ~clk;

   decode_stage_pipe_if #(.XLEN(32)) b32 ();
   decode_stage_pipe_if #(.XLEN(64)) b64 ();

   decode_stage_pipe #(.XLEN(32), .SKID_EN(1'b1)) u_dut32 (.clk_i(clk), .rst_i(rst), .bus(b32.slave));
   decode_stage_pipe #(.XLEN(64), .SKID_EN(1'b1)) u_dut64 (.clk_i(clk), .rst_i(rst), .bus(b64.slave));

   assign b32.flush_i       = flush;
   assign b32.instr_valid_i = valid;
   assign b32.instr_i       = instr;
   assign b32.pc_i          = pc[31:0];
   assign b32.dec_ready_i   = dec_ready;
   assign b64.flush_i       = flush;
   assign b64.instr_valid_i = valid;
   assign b64.instr_i       = instr;
   assign b64.pc_i          = pc;
   assign b64.dec_ready_i   = dec_ready;

   // Reference decode written from the ISA rules using signed 64-bit arithmetic.
   function automatic exp_t model(logic [31:0] ins, logic [63:0] pcv);
      exp_t   e;
      int     kind;
      longint s;
      longint imm;
      logic   ill;
      s = longint'($signed(ins));
      case (ins[6:0])
         7'h03, 7'h13, 7'h67, 7'h73: kind = 1;
         7'h33:                      kind = 2;
         7'h23:                      kind = 3;
         7'h63:                      kind = 4;
         7'h37, 7'h17:               kind = 5;
         7'h6F:                      kind = 6;
         default:                    kind = 0;
      endcase
      ill = (ins[1:0] != 2'b11) || (kind == 0)
         || (ins[6:0] == 7'h67 && ins[14:12] != 3'd0)
         || (kind == 2 && !(ins[31:25] inside {7'h00, 7'h20, 7'h01}))
         || (kind == 4 && (ins[14:12] == 3'd2 || ins[14:12] == 3'd3));
      case (kind)
         1: imm = s >>> 20;
         3: imm = ((s >>> 25) <<< 5) | longint'(ins[11:7]);
         4: imm = ((s >>> 31) <<< 12) | (longint'(ins[7]) << 11)
                | (longint'(ins[30:25]) << 5) | (longint'(ins[11:8]) << 1);
         5: imm = s & ~longint'(12'hFFF);
         6: imm = ((s >>> 31) <<< 20) | (longint'(ins[19:12]) << 12)
                | (longint'(ins[20]) << 11) | (longint'(ins[30:21]) << 1);
         default: imm = 0;
      endcase
      if (ill) imm = 0;
      e.pc       = pcv;
      e.opcode   = ins[6:0];
      e.func3    = ins[14:12];
      e.func7    = ins[31:25];
      e.rs1      = ins[19:15];
      e.rs2      = ins[24:20];
      e.rd       = ins[11:7];
      e.immed    = imm;
      e.typ      = ill ? 6'd0 : 6'(1 << (kind - 1));
      e.illegal  = ill;
      e.rd_we    = !ill && (kind inside {1, 2, 5, 6}) && (ins[11:7] != 5'd0);
      e.rs1_used = !ill && (kind inside {1, 2, 3, 4});
      e.rs2_used = !ill && (kind inside {2, 3, 4});
      return e;
   endfunction

   function automatic exp_t act32();
      exp_t a;
      a = '{pc: {32'd0, b32.pc_o}, opcode: b32.opcode_o, func3: b32.func3_o, func7: b32.func7_o,
            rs1: b32.rs1_o, rs2: b32.rs2_o, rd: b32.rd_o, immed: {32'd0, b32.immed_o},
            typ: b32.type_o, illegal: b32.illegal_o, rd_we: b32.rd_we_o,
            rs1_used: b32.rs1_used_o, rs2_used: b32.rs2_used_o};
      return a;
   endfunction

   function automatic exp_t act64();
      exp_t a;
      a = '{pc: b64.pc_o, opcode: b64.opcode_o, func3: b64.func3_o, func7: b64.func7_o,
            rs1: b64.rs1_o, rs2: b64.rs2_o, rd: b64.rd_o, immed: b64.immed_o,
            typ: b64.type_o, illegal: b64.illegal_o, rd_we: b64.rd_we_o,
            rs1_used: b64.rs1_used_o, rs2_used: b64.rs2_used_o};
      return a;
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_entry(string name, exp_t act, exp_t exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] r;
      logic [6:0]  ops [9];
      logic [6:0]  f7s [3];
      ops = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h33, 7'h23, 7'h63, 7'h37, 7'h6F};
      f7s = '{7'h00, 7'h20, 7'h01};
      r = $urandom;
      if ($urandom_range(0, 9) != 0) begin
         r[6:0] = ops[$urandom_range(0, 8)];
         if ($urandom_range(0, 1) == 1) r[31:25] = f7s[$urandom_range(0, 2)];
         if ($urandom_range(0, 3) == 0) r[14:12] = 3'd0;
      end
      return r;
   endfunction

   // Output monitor, XLEN=32 instance: every valid cycle must show the queue head.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && b32.dec_valid_o) begin
         if (q32.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL dec32_entry: unexpected output %h, expected none", act32());
         end else begin
            e = q32[0];
            e.pc[63:32]    = 32'd0;
            e.immed[63:32] = 32'd0;
            chk_entry("dec32_entry", act32(), e);
            if (b32.dec_ready_i && !b32.flush_i) void'(q32.pop_front());
         end
      end
   end

   // Output monitor, XLEN=64 instance.
   always @(negedge clk) begin
      if (!rst && b64.dec_valid_o) begin
         if (q64.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL dec64_entry: unexpected output %h, expected none", act64());
         end else begin
            chk_entry("dec64_entry", act64(), q64[0]);
            if (b64.dec_ready_i && !b64.flush_i) void'(q64.pop_front());
         end
      end
   end

   // Input side: push the expected entry for each accepted word; flush/reset drop all.
   always @(negedge clk) begin
      #1;
      if (rst || flush) begin
         q32.delete();
         q64.delete();
      end else begin
         if (b32.instr_valid_i && b32.instr_ready_o) q32.push_back(model(instr, pc));
         if (b64.instr_valid_i && b64.instr_ready_o) q64.push_back(model(instr, pc));
      end
   end

   task automatic send(logic [31:0] i, logic [63:0] p);
      bit done;
      done  = 1'b0;
      instr = i;
      pc    = p;
      valid = 1'b1;
      for (int n = 0; n < 50 && !done; n++) begin
         @(negedge clk);
         if (b32.instr_ready_o) begin
            @(posedge clk);
            #1;
            done = 1'b1;
         end
      end
      if (!done) begin
         checks++;
         failures++;
         $display("FAIL send_timeout: instr %h not accepted, got ready=%b expected 1", i, b32.instr_ready_o);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset();
      chk("rst_valid32", b32.dec_valid_o, 0);
      chk("rst_ready32", b32.instr_ready_o, 1);
      chk_entry("rst_out32", act32(), '0);
      chk("rst_valid64", b64.dec_valid_o, 0);
      chk("rst_ready64", b64.instr_ready_o, 1);
      chk_entry("rst_out64", act64(), '0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      flush = 1'b0; valid = 1'b0; dec_ready = 1'b0; instr = '0; pc = '0;
      #1 rst = 1'b1;
      #2 check_reset();
      cycle();
      rst = 1'b0;
      cycle();

      // addi x1,x2,-1
      dec_ready = 1'b1;
      send(32'hFFF10093, 64'h100);
      valid = 1'b0;
      chk("addi_valid", b32.dec_valid_o, 1);
      chk("addi_type", b32.type_o, 6'b000001);
      chk("addi_rs1", b32.rs1_o, 2);
      chk("addi_rd", b32.rd_o, 1);
      chk("addi_imm", b32.immed_o, 32'hFFFF_FFFF);
      chk("addi_rdwe", b32.rd_we_o, 1);
      chk("addi_rs2used", b32.rs2_used_o, 0);
      cycle();

      // sw / beq / jal back to back
      send(32'h00532423, 64'h200);
      chk("sw_valid", b32.dec_valid_o, 1);
      chk("sw_imm", b32.immed_o, 8);
      chk("sw_rs1", b32.rs1_o, 6);
      chk("sw_rs2", b32.rs2_o, 5);
      chk("sw_rdwe", b32.rd_we_o, 0);
      send(32'hFE000EE3, 64'h204);
      chk("beq_valid", b32.dec_valid_o, 1);
      chk("beq_imm", b32.immed_o, 32'hFFFF_FFFC);
      send(32'h001000EF, 64'h208);
      valid = 1'b0;
      chk("jal_valid", b32.dec_valid_o, 1);
      chk("jal_imm", b32.immed_o, 32'h0000_0800);
      chk("jal_rdwe", b32.rd_we_o, 1);
      cycle();

      // Backpressure: A held, B in skid, C stalled
      dec_ready = 1'b0;
      send(32'h002081B3, 64'h300);
      send(32'h40208233, 64'h304);
      instr = 32'h00C00293; pc = 64'h308; valid = 1'b1;
      for (int n = 0; n < 3; n++) begin
         chk("bp_ready", b32.instr_ready_o, 0);
         chk("bp_hold_pc", b32.pc_o, 32'h300);
         cycle();
      end
      dec_ready = 1'b1;
      cycle();
      chk("bp_second_pc", b32.pc_o, 32'h304);
      cycle();
      valid = 1'b0;
      chk("bp_third_pc", b32.pc_o, 32'h308);
      cycle();
      chk("bp_drained", b32.dec_valid_o, 0);

      // Illegal encodings
      send(32'h00000000, 64'h400);
      valid = 1'b0;
      chk("ill0_flag", b32.illegal_o, 1);
      chk("ill0_type", b32.type_o, 0);
      chk("ill0_rdwe", b32.rd_we_o, 0);
      cycle();
      send(32'h0000A067, 64'h404);
      valid = 1'b0;
      chk("illjalr_flag", b32.illegal_o, 1);
      chk("illjalr_type", b32.type_o, 0);
      chk("illjalr_rdwe", b32.rd_we_o, 0);
      cycle();

      // Flush with two stalled entries, then with one stalled (input open)
      for (int k = 2; k >= 1; k--) begin
         dec_ready = 1'b0;
         send(32'h00100093, 64'h500);
         if (k == 2) send(32'h00200113, 64'h504);
         instr = 32'h00300193; pc = 64'h508; valid = 1'b1; flush = 1'b1;
         cycle();
         flush = 1'b0; valid = 1'b0;
         chk("flush_valid", b32.dec_valid_o, 0);
         chk("flush_ready", b32.instr_ready_o, 1);
         dec_ready = 1'b1;
         for (int n = 0; n < 3; n++) begin
            cycle();
            chk("flush_no_emerge", b32.dec_valid_o, 0);
         end
      end

      // lui x1,0x80000 on both widths
      send(32'h800000B7, 64'h1234_5678_9ABC_DEF0);
      valid = 1'b0;
      chk("lui64_imm", b64.immed_o, 64'hFFFF_FFFF_8000_0000);
      chk("lui32_imm", b32.immed_o, 32'h8000_0000);
      chk("lui64_pc", b64.pc_o, 64'h1234_5678_9ABC_DEF0);
      cycle();

      // Random traffic with random backpressure and occasional flush
      for (int n = 0; n < 3000; n++) begin
         valid     = ($urandom_range(0, 3) != 0);
         instr     = rand_instr();
         pc        = {$urandom, $urandom};
         dec_ready = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 40) == 0);
         cycle();
      end
      flush = 1'b0; valid = 1'b0; dec_ready = 1'b1;
      repeat (5) cycle();
      chk("drain32", q32.size(), 0);
      chk("drain64", q64.size(), 0);

      // Asynchronous reset in the middle of a stall
      dec_ready = 1'b0;
      send(32'h00100093, 64'h600);
      send(32'h00200113, 64'h604);
      valid = 1'b0;
      #2 rst = 1'b1;
      #1 check_reset();
      cycle();
      rst = 1'b0;
      dec_ready = 1'b1;
      cycle();
      chk("post_rst_valid", b32.dec_valid_o, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
